// File: rtl/apb_xfer_subsystem.sv
// APB subsystem: valid/ready request port, APB master FSM, slave register file.
// Ports: pclk/prst_n, req_* request side, rsp_* one-cycle response, psel/penable/pready debug.
module apb_xfer_subsystem #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 16,
  parameter int WAIT_STATES = 0
) (
  input  logic                pclk,
  input  logic                prst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_strb,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                psel,
  output logic                penable,
  output logic                pready
);

  localparam int STRB_W = DATA_W / 8;
  localparam int ADDR_LSB = $clog2(STRB_W);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] SPAN = ADDR_W'(DEPTH * STRB_W);
  localparam logic [ADDR_W-1:0] MASK = ADDR_W'(STRB_W - 1);
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_t;

  state_t state, state_nx;

  logic [3:0]        cnt;
  logic              rdy_en;
  logic              wr_q;
  logic              err_q;
  logic [IDX_W-1:0]  idx_q;
  logic [DATA_W-1:0] wdata_q;
  logic [STRB_W-1:0] strb_q;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              accept;
  logic              bad;

  assign accept = req_valid && req_ready;
  // Mask test instead of a low-bit slice so DATA_W=8 (no offset bits) works.
  assign bad = (req_addr >= SPAN) || ((req_addr & MASK) != '0);

  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept) state_nx = SETUP;
      SETUP:   state_nx = ACCESS;
      ACCESS:  if (pready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // rdy_en keeps req_ready low until the first edge after reset.
  always_comb begin
    req_ready = rdy_en && (state == IDLE);
    psel      = (state != IDLE);
    penable   = (state == ACCESS);
    pready    = (state == ACCESS) && (cnt == WS);
  end

  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) begin
      rdy_en  <= 1'b0;
      cnt     <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
    end else begin
      rdy_en <= 1'b1;
      cnt    <= (penable && !pready) ? cnt + 4'd1 : 4'd0;
      if (accept) begin
        wr_q    <= req_write;
        err_q   <= bad;
        idx_q   <= req_addr[ADDR_LSB +: IDX_W];
        wdata_q <= req_wdata;
        strb_q  <= req_strb;
      end
    end
  end

  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      rsp_valid <= pready;
      rsp_err   <= pready && err_q;
      rsp_rdata <= (pready && !err_q && !wr_q) ? mem[idx_q] : '0;
      if (pready && wr_q && !err_q) begin
        for (int b = 0; b < STRB_W; b++) begin
          if (strb_q[b]) mem[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_apb_xfer_subsystem.sv
// Bench for apb_xfer_subsystem: two instances (0 and 3 wait states) share stimulus.
// Vector table plus hand sequences for reset and mid-transfer reset.
module tb_apb_xfer_subsystem;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid;
  logic        write;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  strb;

  logic        rdy [2];
  logic        rv  [2];
  logic [31:0] rd  [2];
  logic        er  [2];
  logic        ps  [2];
  logic        pe  [2];
  logic        pr  [2];

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  apb_xfer_subsystem #(
    .ADDR_W(32), .DATA_W(32), .DEPTH(16), .WAIT_STATES(0)
  ) u_ws0 (
    .pclk(clk), .prst_n(rst_n),
    .req_valid(valid), .req_ready(rdy[0]),
    .req_write(write), .req_addr(addr),
    .req_wdata(wdata), .req_strb(strb),
    .rsp_valid(rv[0]), .rsp_rdata(rd[0]), .rsp_err(er[0]),
    .psel(ps[0]), .penable(pe[0]), .pready(pr[0])
  );

  apb_xfer_subsystem #(
    .ADDR_W(32), .DATA_W(32), .DEPTH(16), .WAIT_STATES(3)
  ) u_ws3 (
    .pclk(clk), .prst_n(rst_n),
    .req_valid(valid), .req_ready(rdy[1]),
    .req_write(write), .req_addr(addr),
    .req_wdata(wdata), .req_strb(strb),
    .rsp_valid(rv[1]), .rsp_rdata(rd[1]), .rsp_err(er[1]),
    .psel(ps[1]), .penable(pe[1]), .pready(pr[1])
  );

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
    logic [31:0] ed;
    logic        ee;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  function automatic vec_t mk(input logic w, input logic [31:0] a,
                              input logic [31:0] d, input logic [3:0] s,
                              input logic [31:0] ed, input logic ee);
    vec_t v;
    v.w = w; v.a = a; v.d = d; v.s = s; v.ed = ed; v.ee = ee;
    return v;
  endfunction

  // Call at a negedge with both instances idle; returns at a negedge.
  task automatic xfer(input string tag, input vec_t v);
    int          lat [2];
    int          pulses [2];
    int          waits [2];
    logic [31:0] gd [2];
    logic        ge [2];
    logic        gr [2];
    int          cyc;
    for (int j = 0; j < 2; j++) begin
      lat[j] = 0; pulses[j] = 0; waits[j] = 0;
      gd[j] = '0; ge[j] = 1'b0; gr[j] = 1'b0;
    end
    valid = 1'b1; write = v.w; addr = v.a; wdata = v.d; strb = v.s;
    chk({tag, " ready"}, {rdy[0], rdy[1]}, 2'b11);
    @(posedge clk);
    #1;
    valid = 1'b0; write = ~v.w; addr = 32'hFFFF_FFF3;
    wdata = ~v.d; strb = ~v.s;
    cyc = 1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      for (int j = 0; j < 2; j++) begin
        if (ps[j] && pe[j] && !pr[j]) waits[j]++;
        if (rv[j]) begin
          pulses[j]++;
          if (pulses[j] == 1) begin
            lat[j] = cyc; gd[j] = rd[j]; ge[j] = er[j]; gr[j] = rdy[j];
          end
        end
      end
      cyc++;
    end
    for (int j = 0; j < 2; j++) begin
      string p;
      p = $sformatf("%s ws%0d", tag, j * 3);
      chk({p, " pulses"}, pulses[j], 1);
      chk({p, " latency"}, lat[j], 3 + 3 * j);
      chk({p, " waits"}, waits[j], 3 * j);
      chk({p, " rdata"}, gd[j], v.ed);
      chk({p, " err"}, ge[j], v.ee);
      chk({p, " rsp ready"}, gr[j], 1'b1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    rst_n = 1'b0; valid = 1'b0; write = 1'b0;
    addr = '0; wdata = '0; strb = '0;

    for (int i = 0; i <= 10; i++)
      tbl.push_back(mk(1'b1, 32'(4 * i), 32'(i * 5), 4'hF, 32'h0, 1'b0));
    for (int i = 0; i <= 10; i++)
      tbl.push_back(mk(1'b0, 32'(4 * i), 32'h0, 4'hF, 32'(i * 5), 1'b0));
    tbl.push_back(mk(1'b1, 32'h40, 32'hDEAD_0001, 4'hF, 32'h0, 1'b1));
    tbl.push_back(mk(1'b1, 32'h2, 32'hBEEF_0002, 4'hF, 32'h0, 1'b1));
    tbl.push_back(mk(1'b0, 32'h0, 32'h0, 4'hF, 32'h0, 1'b0));
    tbl.push_back(mk(1'b0, 32'h44, 32'h0, 4'hF, 32'h0, 1'b1));
    tbl.push_back(mk(1'b0, 32'h3, 32'h0, 4'hF, 32'h0, 1'b1));
    tbl.push_back(mk(1'b1, 32'h8, 32'hAABB_CCDD, 4'hF, 32'h0, 1'b0));
    tbl.push_back(mk(1'b1, 32'h8, 32'h1122_3344, 4'h5, 32'h0, 1'b0));
    tbl.push_back(mk(1'b0, 32'h8, 32'h0, 4'hF, 32'hAA22_CC44, 1'b0));
    tbl.push_back(mk(1'b1, 32'hC, 32'hFFFF_FFFF, 4'h0, 32'h0, 1'b0));
    tbl.push_back(mk(1'b0, 32'hC, 32'h0, 4'hF, 32'd15, 1'b0));
    tbl.push_back(mk(1'b0, 32'h3C, 32'h0, 4'hF, 32'h0, 1'b0));

    repeat (4) @(posedge clk);
    @(negedge clk);
    for (int j = 0; j < 2; j++)
      chk($sformatf("reset outs ws%0d", 3 * j),
          {rdy[j], rv[j], rd[j], er[j], ps[j], pe[j], pr[j]}, 64'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ready after release", {rdy[0], rdy[1]}, 2'b11);
    @(negedge clk);

    foreach (tbl[i]) xfer($sformatf("vec%0d", i), tbl[i]);

    // Reset while both instances sit in ACCESS of a write to 0xC.
    valid = 1'b1; write = 1'b1; addr = 32'hC;
    wdata = 32'h1234_5678; strb = 4'hF;
    @(posedge clk);
    #1;
    valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid access ws0", {ps[0], pe[0]}, 2'b11);
    chk("mid access ws3", {ps[1], pe[1]}, 2'b11);
    rst_n = 1'b0;
    n = 0;
    for (int k = 0; k < 4; k++) begin
      #1;
      if (rv[0] || rv[1]) n++;
      @(negedge clk);
    end
    chk("mid reset outs", {rdy[0], rdy[1], ps[0], ps[1], pe[0], pe[1]}, 6'h0);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (rv[0] || rv[1]) n++;
    end
    chk("abort no rsp", n, 0);
    xfer("after abort", mk(1'b0, 32'hC, 32'h0, 4'hF, 32'h0, 1'b0));
    xfer("after abort w8", mk(1'b0, 32'h8, 32'h0, 4'hF, 32'h0, 1'b0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
